// File: rtl/video_mnist_class_histogram_pkg.sv
// -----------------------------------------------------------------------------
// mnist_hist_pkg
// Shared definitions for the MNIST class histogram block:
//   - hist_state_t : arg-max scan FSM states
//   - sat_inc      : saturating increment for histogram counters (width <= 32)
//   - none_class   : "no dominant digit" class index, clipped to the class field
// -----------------------------------------------------------------------------
package mnist_hist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } hist_state_t;

    // Counters are carried in a 32-bit container; values stick at the
    // all-ones pattern of the real counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_v;
        if (width >= 32) begin
            max_v = 32'hFFFF_FFFF;
        end else begin
            max_v = (32'd1 << width) - 32'd1;
        end
        if (value >= max_v) begin
            return max_v;
        end else begin
            return value + 32'd1;
        end
    endfunction

    // The ignored class doubles as the "none" result; when it does not fit the
    // class field it saturates to the largest representable index.
    function automatic int none_class(input int ignore_class, input int tnumber_width);
        int max_idx;
        max_idx = (1 << tnumber_width) - 1;
        if (ignore_class > max_idx) begin
            return max_idx;
        end else begin
            return ignore_class;
        end
    endfunction

endpackage

// File: rtl/video_mnist_class_histogram_if.sv
// -----------------------------------------------------------------------------
// video_mnist_class_histogram_if
// AXI4-Stream bundle carrying the per-pixel class stream.
//   tuser[0] frame start, tlast end of line, tnumber class index,
//   tcount detection count (0 = none), tclustering cluster vector,
//   tvalid/tready handshake.
// Modports: master drives the payload and tvalid, slave drives tready.
// -----------------------------------------------------------------------------
interface video_mnist_class_histogram_if #(
    parameter int TUSER_WIDTH       = 1,
    parameter int TNUMBER_WIDTH     = 4,
    parameter int TCOUNT_WIDTH      = 1,
    parameter int TCLUSTERING_WIDTH = 11
) ();
    logic [TUSER_WIDTH-1:0]       tuser;
    logic                         tlast;
    logic [TNUMBER_WIDTH-1:0]     tnumber;
    logic [TCOUNT_WIDTH-1:0]      tcount;
    logic [TCLUSTERING_WIDTH-1:0] tclustering;
    logic                         tvalid;
    logic                         tready;

    modport master (
        output tuser, tlast, tnumber, tcount, tclustering, tvalid,
        input  tready
    );

    modport slave (
        input  tuser, tlast, tnumber, tcount, tclustering, tvalid,
        output tready
    );
endinterface

// File: rtl/video_axi4s_pipeline_reg.sv
// -----------------------------------------------------------------------------
// video_axi4s_pipeline_reg
// Generic one-stage registered AXI4-Stream slice (latency 1, full throughput).
//   clk, reset        : clock, asynchronous active-high reset
//   i_data/i_valid    : upstream payload and valid
//   o_ready           : upstream ready (= !o_valid || i_ready)
//   o_data/o_valid    : registered downstream payload and valid
//   i_ready           : downstream ready
// -----------------------------------------------------------------------------
module video_axi4s_pipeline_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // The stage can take a beat whenever it is empty or is being drained.
    assign o_ready = !r_valid || i_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    // Output register: load on any upstream transfer, hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_WIDTH{1'b0}};
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end
endmodule

// File: rtl/video_mnist_class_histogram.sv
// -----------------------------------------------------------------------------
// video_mnist_class_histogram
// Forwards the per-pixel class stream through a registered AXI4-Stream slice
// and, per frame, histograms the detected classes and reports the dominant one.
//   clk, reset        : clock, asynchronous active-high reset
//   s_axi4s (slave)   : incoming class stream
//   m_axi4s (master)  : forwarded class stream, latency 1
//   m_result_number   : dominant class of the last closed frame (none = NONE_CLASS)
//   m_result_count    : pixel count of that class
//   m_result_total    : counted pixels of that frame, all classes
//   m_result_overrun  : 1-cycle pulse, running scan aborted by a new frame
//   m_result_valid    : 1-cycle pulse, result registers updated
// -----------------------------------------------------------------------------
module video_mnist_class_histogram
    import mnist_hist_pkg::*;
#(
    parameter int NUM_CALSS         = 11,
    parameter int TUSER_WIDTH       = 1,
    parameter int TNUMBER_WIDTH     = 4,
    parameter int TCOUNT_WIDTH      = 1,
    parameter int TCLUSTERING_WIDTH = NUM_CALSS,
    parameter int HIST_WIDTH        = 20,
    parameter int IGNORE_CLASS      = NUM_CALSS - 1
) (
    input  logic                      clk,
    input  logic                      reset,
    video_mnist_class_histogram_if.slave  s_axi4s,
    video_mnist_class_histogram_if.master m_axi4s,
    output logic [TNUMBER_WIDTH-1:0]  m_result_number,
    output logic [HIST_WIDTH-1:0]     m_result_count,
    output logic [HIST_WIDTH-1:0]     m_result_total,
    output logic                      m_result_overrun,
    output logic                      m_result_valid
);
    localparam int DATA_W = TUSER_WIDTH + 1 + TNUMBER_WIDTH + TCOUNT_WIDTH + TCLUSTERING_WIDTH;
    localparam logic [TNUMBER_WIDTH-1:0] NONE_CLASS =
        TNUMBER_WIDTH'(none_class(IGNORE_CLASS, TNUMBER_WIDTH));
    localparam logic [TNUMBER_WIDTH-1:0] IDX_ONE  = TNUMBER_WIDTH'(1);
    localparam logic [HIST_WIDTH-1:0]    CNT_ZERO = {HIST_WIDTH{1'b0}};
    localparam logic [HIST_WIDTH-1:0]    CNT_ONE  = HIST_WIDTH'(1);

    // ---------------- stream forwarding ----------------
    logic [DATA_W-1:0] w_s_data;
    logic [DATA_W-1:0] w_m_data;
    logic              w_s_ready;
    logic              w_m_valid;

    assign w_s_data = {s_axi4s.tuser, s_axi4s.tlast, s_axi4s.tnumber,
                       s_axi4s.tcount, s_axi4s.tclustering};

    video_axi4s_pipeline_reg #(
        .DATA_WIDTH (DATA_W)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_data  (w_s_data),
        .i_valid (s_axi4s.tvalid),
        .o_ready (w_s_ready),
        .o_data  (w_m_data),
        .o_valid (w_m_valid),
        .i_ready (m_axi4s.tready)
    );

    assign s_axi4s.tready = w_s_ready;
    assign m_axi4s.tvalid = w_m_valid;
    assign {m_axi4s.tuser, m_axi4s.tlast, m_axi4s.tnumber,
            m_axi4s.tcount, m_axi4s.tclustering} = w_m_data;

    // ---------------- histogram ----------------
    logic                     w_accept;
    logic                     w_hit;
    logic                     w_boundary;
    logic                     w_start;
    logic                     r_frame_open;
    logic [HIST_WIDTH-1:0]    r_hist [NUM_CALSS];
    logic [HIST_WIDTH-1:0]    r_snap [NUM_CALSS];
    logic [HIST_WIDTH-1:0]    r_total;
    logic [HIST_WIDTH-1:0]    r_snap_total;

    assign w_accept   = s_axi4s.tvalid && w_s_ready;
    // Out-of-range class indices are never counted.
    assign w_hit      = w_accept && (s_axi4s.tcount != {TCOUNT_WIDTH{1'b0}})
                        && (int'(s_axi4s.tnumber) < NUM_CALSS);
    assign w_boundary = w_accept && s_axi4s.tuser[0];
    // The first frame start after reset only opens a frame; later ones close one.
    assign w_start    = w_boundary && r_frame_open;

    // Counters: snapshot+clear on a closing boundary, with the boundary beat's
    // own hit landing in the freshly cleared counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CALSS; i++) begin
                r_hist[i] <= CNT_ZERO;
                r_snap[i] <= CNT_ZERO;
            end
            r_total      <= CNT_ZERO;
            r_snap_total <= CNT_ZERO;
            r_frame_open <= 1'b0;
        end else begin
            if (w_start) begin
                for (int i = 0; i < NUM_CALSS; i++) begin
                    r_snap[i] <= r_hist[i];
                    r_hist[i] <= (w_hit && (s_axi4s.tnumber == TNUMBER_WIDTH'(i))) ? CNT_ONE : CNT_ZERO;
                end
                r_snap_total <= r_total;
                r_total      <= w_hit ? CNT_ONE : CNT_ZERO;
            end else if (w_hit) begin
                for (int i = 0; i < NUM_CALSS; i++) begin
                    if (s_axi4s.tnumber == TNUMBER_WIDTH'(i)) begin
                        r_hist[i] <= HIST_WIDTH'(sat_inc(32'(r_hist[i]), HIST_WIDTH));
                    end
                end
                r_total <= HIST_WIDTH'(sat_inc(32'(r_total), HIST_WIDTH));
            end
            if (w_boundary) begin
                r_frame_open <= 1'b1;
            end
        end
    end

    // ---------------- arg-max scan FSM ----------------
    hist_state_t              r_state;
    hist_state_t              w_state_nxt;
    logic [TNUMBER_WIDTH-1:0] r_idx;
    logic [TNUMBER_WIDTH-1:0] w_idx_nxt;
    logic [HIST_WIDTH-1:0]    r_best_cnt;
    logic [HIST_WIDTH-1:0]    w_best_cnt_nxt;
    logic [TNUMBER_WIDTH-1:0] r_best_idx;
    logic [TNUMBER_WIDTH-1:0] w_best_idx_nxt;
    logic [TNUMBER_WIDTH-1:0] r_res_number;
    logic [TNUMBER_WIDTH-1:0] w_res_number_nxt;
    logic [HIST_WIDTH-1:0]    r_res_count;
    logic [HIST_WIDTH-1:0]    w_res_count_nxt;
    logic [HIST_WIDTH-1:0]    r_res_total;
    logic [HIST_WIDTH-1:0]    w_res_total_nxt;
    logic                     r_res_valid;
    logic                     w_res_valid_nxt;
    logic                     r_res_overrun;
    logic                     w_res_overrun_nxt;
    logic                     w_take;
    logic                     w_last_idx;

    // Strict compare keeps the lowest index on ties.
    assign w_take     = (int'(r_idx) != IGNORE_CLASS) && (r_snap[r_idx] > r_best_cnt);
    assign w_last_idx = (int'(r_idx) == NUM_CALSS - 1);

    // Next-state and result logic; a closing boundary always (re)starts the scan.
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_best_cnt_nxt    = r_best_cnt;
        w_best_idx_nxt    = r_best_idx;
        w_res_number_nxt  = r_res_number;
        w_res_count_nxt   = r_res_count;
        w_res_total_nxt   = r_res_total;
        w_res_valid_nxt   = 1'b0;
        w_res_overrun_nxt = 1'b0;
        if (w_start) begin
            w_state_nxt       = ST_SCAN;
            w_idx_nxt         = {TNUMBER_WIDTH{1'b0}};
            w_best_cnt_nxt    = CNT_ZERO;
            w_best_idx_nxt    = NONE_CLASS;
            w_res_overrun_nxt = (r_state != ST_IDLE);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_SCAN: begin
                    if (w_take) begin
                        w_best_cnt_nxt = r_snap[r_idx];
                        w_best_idx_nxt = r_idx;
                    end else begin
                        w_best_cnt_nxt = r_best_cnt;
                    end
                    if (w_last_idx) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt      = ST_IDLE;
                    w_res_number_nxt = r_best_idx;
                    w_res_count_nxt  = r_best_cnt;
                    w_res_total_nxt  = r_snap_total;
                    w_res_valid_nxt  = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, scan bookkeeping and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= {TNUMBER_WIDTH{1'b0}};
            r_best_cnt    <= CNT_ZERO;
            r_best_idx    <= NONE_CLASS;
            r_res_number  <= {TNUMBER_WIDTH{1'b0}};
            r_res_count   <= CNT_ZERO;
            r_res_total   <= CNT_ZERO;
            r_res_valid   <= 1'b0;
            r_res_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_best_cnt    <= w_best_cnt_nxt;
            r_best_idx    <= w_best_idx_nxt;
            r_res_number  <= w_res_number_nxt;
            r_res_count   <= w_res_count_nxt;
            r_res_total   <= w_res_total_nxt;
            r_res_valid   <= w_res_valid_nxt;
            r_res_overrun <= w_res_overrun_nxt;
        end
    end

    assign m_result_number  = r_res_number;
    assign m_result_count   = r_res_count;
    assign m_result_total   = r_res_total;
    assign m_result_valid   = r_res_valid;
    assign m_result_overrun = r_res_overrun;
endmodule

// File: tb/tb_video_mnist_class_histogram.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for video_mnist_class_histogram.
// A second instance with 4-bit counters shares the input stream (always ready)
// to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_video_mnist_class_histogram;
    localparam int DW = 18;

    logic clk;
    logic reset;

    video_mnist_class_histogram_if #(.TUSER_WIDTH(1), .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(1), .TCLUSTERING_WIDTH(11)) s_if ();
    video_mnist_class_histogram_if #(.TUSER_WIDTH(1), .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(1), .TCLUSTERING_WIDTH(11)) m_if ();
    video_mnist_class_histogram_if #(.TUSER_WIDTH(1), .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(1), .TCLUSTERING_WIDTH(11)) s2_if ();
    video_mnist_class_histogram_if #(.TUSER_WIDTH(1), .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(1), .TCLUSTERING_WIDTH(11)) m2_if ();

    logic [3:0]  res_number;
    logic [19:0] res_count;
    logic [19:0] res_total;
    logic        res_overrun;
    logic        res_valid;
    logic [3:0]  r2_number;
    logic [3:0]  r2_count;
    logic [3:0]  r2_total;
    logic        r2_overrun;
    logic        r2_valid;

    video_mnist_class_histogram dut (
        .clk              (clk),
        .reset            (reset),
        .s_axi4s          (s_if),
        .m_axi4s          (m_if),
        .m_result_number  (res_number),
        .m_result_count   (res_count),
        .m_result_total   (res_total),
        .m_result_overrun (res_overrun),
        .m_result_valid   (res_valid)
    );

    video_mnist_class_histogram #(.HIST_WIDTH(4)) dut_sat (
        .clk              (clk),
        .reset            (reset),
        .s_axi4s          (s2_if),
        .m_axi4s          (m2_if),
        .m_result_number  (r2_number),
        .m_result_count   (r2_count),
        .m_result_total   (r2_total),
        .m_result_overrun (r2_overrun),
        .m_result_valid   (r2_valid)
    );

    assign s2_if.tuser       = s_if.tuser;
    assign s2_if.tlast       = s_if.tlast;
    assign s2_if.tnumber     = s_if.tnumber;
    assign s2_if.tcount      = s_if.tcount;
    assign s2_if.tclustering = s_if.tclustering;
    assign s2_if.tvalid      = s_if.tvalid;
    assign m2_if.tready      = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int acc_cyc      = 0;
    int out_cnt      = 0;
    int sb_err       = 0;
    int valid_cnt    = 0;
    int valid_cyc    = 0;
    int ovr_cnt      = 0;
    int v2_cnt       = 0;
    logic [DW-1:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Output monitor: stream scoreboard and result pulse bookkeeping.
    initial begin
        logic [DW-1:0] got;
        logic [DW-1:0] want;
        forever begin
            @(negedge clk);
            if (m_if.tvalid && m_if.tready) begin
                out_cnt = out_cnt + 1;
                got = {m_if.tuser, m_if.tlast, m_if.tnumber, m_if.tcount, m_if.tclustering};
                if (exp_q.size() == 0) begin
                    sb_err = sb_err + 1;
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) sb_err = sb_err + 1;
                end
            end
            if (res_valid)   begin valid_cnt = valid_cnt + 1; valid_cyc = cyc; end
            if (res_overrun) ovr_cnt = ovr_cnt + 1;
            if (r2_valid)    v2_cnt = v2_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic tu, input logic [3:0] num, input logic tc, input logic tl);
        int guard;
        logic [10:0] clus;
        clus = 11'($urandom);
        s_if.tuser = tu; s_if.tlast = tl; s_if.tnumber = num;
        s_if.tcount = tc; s_if.tclustering = clus; s_if.tvalid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!s_if.tready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!s_if.tready) begin
            tests_run++; tests_failed++;
            $display("FAIL send_beat: tready %b after 50 clk, required 1", s_if.tready);
        end else begin
            exp_q.push_back({tu, tl, num, tc, clus});
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_result(input int prev);
        int g;
        g = 0;
        while (valid_cnt == prev && g < 40) begin
            @(posedge clk); #1; g++;
        end
        if (valid_cnt == prev) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_result: pulses %0d within 40 clk, required 1", valid_cnt - prev);
        end
    endtask

    task automatic test_reset;
        s_if.tuser = 1'b0; s_if.tlast = 1'b0; s_if.tnumber = 4'd0; s_if.tcount = 1'b0;
        s_if.tclustering = 11'd0; s_if.tvalid = 1'b0; m_if.tready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({m_if.tvalid, res_number, res_count, res_total, res_valid, res_overrun} !== 47'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: tvalid=%b num=%0d cnt=%0d tot=%0d v=%b o=%b, required all 0",
                     m_if.tvalid, res_number, res_count, res_total, res_valid, res_overrun);
        end
        tests_run++;
        if (s_if.tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_tready: got %b, required 1", s_if.tready);
        end
        #3 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_throughput;
        int c0, o0, v0;
        c0 = cyc; o0 = out_cnt; v0 = valid_cnt;
        for (int i = 0; i < 64; i++) begin
            send_beat(i == 0, 4'((i * 7) % 11), (i % 3) != 0, (i % 16) == 15);
            if (i == 0) begin
                tests_run++;
                if (m_if.tvalid !== 1'b1 || m_if.tnumber !== 4'd0 || m_if.tuser !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL tput_latency: tvalid=%b tuser=%b num=%0d, required 1 1 0",
                             m_if.tvalid, m_if.tuser, m_if.tnumber);
                end
            end
        end
        tests_run++;
        if (acc_cyc - c0 != 64) begin
            tests_failed++;
            $display("FAIL tput_cycles: 64 beats took %0d clk, required 64", acc_cyc - c0);
        end
        idle(2);
        tests_run++;
        if (out_cnt - o0 != 64 || sb_err != 0) begin
            tests_failed++;
            $display("FAIL tput_stream: out beats %0d errors %0d, required 64 and 0", out_cnt - o0, sb_err);
        end
        tests_run++;
        if (valid_cnt != v0) begin
            tests_failed++;
            $display("FAIL first_frame: result pulses %0d, required 0", valid_cnt - v0);
        end
    endtask

    task automatic test_backpressure;
        bit done;
        int c0, o0, v0;
        done = 1'b0; c0 = cyc; o0 = out_cnt;
        fork
            begin
                for (int i = 0; i < 100; i++) send_beat(i == 0, 4'(i % 11), 1'b1, 1'b0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_if.tready = (cyc % 4 != 3);
                    @(posedge clk); #1;
                end
                m_if.tready = 1'b1;
            end
        join
        idle(3);
        tests_run++;
        if (out_cnt - o0 != 100 || sb_err != 0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_stream: out beats %0d errors %0d pending %0d, required 100 0 0",
                     out_cnt - o0, sb_err, exp_q.size());
        end
        tests_run++;
        if (acc_cyc - c0 <= 110) begin
            tests_failed++;
            $display("FAIL bp_stalls: 100 beats took %0d clk, required more than 110", acc_cyc - c0);
        end
        v0 = valid_cnt;
        send_beat(1'b1, 4'd0, 1'b0, 1'b0);
        wait_result(v0);
        tests_run++;
        if (res_number !== 4'd0 || res_count !== 20'd10 || res_total !== 20'd100) begin
            tests_failed++;
            $display("FAIL bp_result: num=%0d cnt=%0d tot=%0d, required 0 10 100", res_number, res_count, res_total);
        end
    endtask

    task automatic test_basic_frame;
        int v0, o0, a;
        v0 = valid_cnt; o0 = ovr_cnt;
        for (int i = 0; i < 10; i++) send_beat(1'b0, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++)  send_beat(1'b0, 4'd5, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) send_beat(1'b0, 4'd10, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)  send_beat(1'b0, 4'd4, 1'b0, 1'b0);
        send_beat(1'b1, 4'd0, 1'b0, 1'b0);
        a = acc_cyc;
        wait_result(v0);
        tests_run++;
        if (res_number !== 4'd3 || res_count !== 20'd10 || res_total !== 20'd37) begin
            tests_failed++;
            $display("FAIL basic_result: num=%0d cnt=%0d tot=%0d, required 3 10 37", res_number, res_count, res_total);
        end
        tests_run++;
        if (valid_cyc - a != 12) begin
            tests_failed++;
            $display("FAIL basic_latency: %0d clk, required 12", valid_cyc - a);
        end
        tests_run++;
        if (ovr_cnt != o0) begin
            tests_failed++;
            $display("FAIL basic_overrun: pulses %0d, required 0", ovr_cnt - o0);
        end
    endtask

    task automatic test_tie_none;
        int v0;
        v0 = valid_cnt;
        for (int i = 0; i < 4; i++) begin
            send_beat(1'b0, 4'd7, 1'b1, 1'b0);
            send_beat(1'b0, 4'd2, 1'b1, 1'b0);
        end
        send_beat(1'b1, 4'd0, 1'b0, 1'b0);
        wait_result(v0);
        tests_run++;
        if (res_number !== 4'd2 || res_count !== 20'd4 || res_total !== 20'd8) begin
            tests_failed++;
            $display("FAIL tie_result: num=%0d cnt=%0d tot=%0d, required 2 4 8", res_number, res_count, res_total);
        end
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) send_beat(1'b0, 4'd5, 1'b0, 1'b0);
        send_beat(1'b0, 4'd12, 1'b1, 1'b0);
        send_beat(1'b0, 4'd15, 1'b1, 1'b0);
        send_beat(1'b1, 4'd0, 1'b0, 1'b0);
        wait_result(v0);
        tests_run++;
        if (res_number !== 4'd10 || res_count !== 20'd0 || res_total !== 20'd0) begin
            tests_failed++;
            $display("FAIL none_result: num=%0d cnt=%0d tot=%0d, required 10 0 0", res_number, res_count, res_total);
        end
    endtask

    task automatic test_short_frames;
        int v0, o0, a;
        v0 = valid_cnt; o0 = ovr_cnt;
        send_beat(1'b1, 4'd6, 1'b1, 1'b0);
        idle(4);
        send_beat(1'b1, 4'd0, 1'b0, 1'b0);
        a = acc_cyc;
        wait_result(v0);
        tests_run++;
        if (valid_cyc - a != 12) begin
            tests_failed++;
            $display("FAIL short_latency: %0d clk, required 12", valid_cyc - a);
        end
        tests_run++;
        if (res_number !== 4'd6 || res_count !== 20'd1 || res_total !== 20'd1) begin
            tests_failed++;
            $display("FAIL short_result: num=%0d cnt=%0d tot=%0d, required 6 1 1", res_number, res_count, res_total);
        end
        idle(15);
        tests_run++;
        if (valid_cnt - v0 != 1 || ovr_cnt - o0 != 1) begin
            tests_failed++;
            $display("FAIL short_pulses: valid %0d overrun %0d, required 1 1", valid_cnt - v0, ovr_cnt - o0);
        end
    endtask

    task automatic test_saturation;
        int v0, w0;
        v0 = valid_cnt; w0 = v2_cnt;
        for (int i = 0; i < 20; i++) send_beat(1'b0, 4'd1, 1'b1, 1'b0);
        send_beat(1'b1, 4'd0, 1'b0, 1'b0);
        wait_result(v0);
        idle(1);
        tests_run++;
        if (res_number !== 4'd1 || res_count !== 20'd20 || res_total !== 20'd20) begin
            tests_failed++;
            $display("FAIL wide_result: num=%0d cnt=%0d tot=%0d, required 1 20 20", res_number, res_count, res_total);
        end
        tests_run++;
        if (v2_cnt - w0 != 1 || r2_number !== 4'd1 || r2_count !== 4'd15 || r2_total !== 4'd15) begin
            tests_failed++;
            $display("FAIL sat_result: pulses=%0d num=%0d cnt=%0d tot=%0d, required 1 1 15 15",
                     v2_cnt - w0, r2_number, r2_count, r2_total);
        end
    endtask

    task automatic test_reset_mid_scan;
        int v0, o0;
        send_beat(1'b1, 4'd3, 1'b1, 1'b0);
        idle(5);
        #3 reset = 1'b1;
        #1;
        tests_run++;
        if ({m_if.tvalid, res_number, res_count, res_total, res_valid, res_overrun} !== 47'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: tvalid=%b num=%0d cnt=%0d tot=%0d v=%b o=%b, required all 0",
                     m_if.tvalid, res_number, res_count, res_total, res_valid, res_overrun);
        end
        tests_run++;
        if ({r2_number, r2_count, r2_total, r2_valid, r2_overrun} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_sat: num=%0d cnt=%0d tot=%0d, required 0 0 0", r2_number, r2_count, r2_total);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        v0 = valid_cnt; o0 = ovr_cnt;
        send_beat(1'b1, 4'd9, 1'b1, 1'b0);
        idle(20);
        tests_run++;
        if (valid_cnt != v0 || ovr_cnt != o0) begin
            tests_failed++;
            $display("FAIL post_reset_first: valid %0d overrun %0d, required 0 0", valid_cnt - v0, ovr_cnt - o0);
        end
        send_beat(1'b1, 4'd0, 1'b0, 1'b0);
        wait_result(v0);
        tests_run++;
        if (res_number !== 4'd9 || res_count !== 20'd1 || res_total !== 20'd1) begin
            tests_failed++;
            $display("FAIL post_reset_result: num=%0d cnt=%0d tot=%0d, required 9 1 1", res_number, res_count, res_total);
        end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_backpressure();
        test_basic_frame();
        test_tie_none();
        test_short_frames();
        test_saturation();
        test_reset_mid_scan();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
